// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg: shared definitions for the mem_fill engine.
//   - Fill-pattern mode codes (MODE_CONST / MODE_INC / MODE_ALT; code 3 behaves as constant).
//   - FSM state encoding. The VERIFY state only exists when MEM_FILL_VERIFY_EN is defined.
package mem_fill_pkg;

  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_ALT   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
`ifdef MEM_FILL_VERIFY_EN
    S_VERIFY = 2'd2,
`endif
    S_FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_fill_pattern.sv
// mem_fill_pattern: combinational fill-pattern generator.
// Ports:
//   mode  in  2       pattern select (MODE_CONST, MODE_INC, MODE_ALT; 3 acts as constant)
//   seed  in  DATA_W  pattern seed (fill_data latched at start)
//   index in  DATA_W  write count modulo 2^DATA_W
//   data  out DATA_W  pattern value for this index
module mem_fill_pattern
  import mem_fill_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] index,
  output logic [DATA_W-1:0] data
);

  // Alternate pattern: every bit of the seed flips on odd indices.
  logic [DATA_W-1:0] alt_data;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_alt
      assign alt_data[gi] = seed[gi] ^ index[0];
    end
  endgenerate

  always_comb begin
    data = seed;
    case (mode)
      MODE_INC: data = seed + index;
      MODE_ALT: data = alt_data;
      default:  data = seed;
    endcase
  end

endmodule

// File: rtl/mem_fill.sv
// mem_fill: writes a programmable pattern over an inclusive (wrapping) address
// range of a single-port RAM, one write per accepted cycle, with start/done
// handshake, RAM backpressure (ram_ready), abort and an optional read-back
// verify pass enabled by the macro MEM_FILL_VERIFY_EN.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, abort                  request (sampled in IDLE) / stop current operation
//   first_addr, last_addr         inclusive range, latched with start
//   fill_data, mode               pattern seed and pattern select, latched with start
//   busy, done, aborted           status; done is a one-cycle pulse, aborted valid with done
//   ram_we, ram_addr, ram_data    write request (accepted when ram_we && ram_ready)
//   ram_ready                     RAM write accept
//   ram_re, ram_rdata             verify read strobe / data one cycle later
//   err, err_addr                 sticky verify mismatch flag and first mismatch address
module mem_fill
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic              ram_ready,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] first_reg, last_reg;
  logic [DATA_W-1:0] seed_reg;
  logic [1:0]        mode_reg;
  // One bit wider than the address so a full-range pass does not alias.
  logic [ADDR_W:0]   index_reg, index_next;
  logic              aborted_reg, aborted_next;
  logic              start_accept;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] wr_pattern;

  assign start_accept = (state_reg == S_IDLE) && start;
  assign cur_addr     = first_reg + index_reg[ADDR_W-1:0];

  mem_fill_pattern #(.DATA_W(DATA_W)) u_wr_pattern (
    .mode  (mode_reg),
    .seed  (seed_reg),
    .index (index_reg[DATA_W-1:0]),
    .data  (wr_pattern)
  );

`ifdef MEM_FILL_VERIFY_EN
  logic [ADDR_W:0]   len_reg;
  logic              verify_rd;
  logic              cmp_valid_reg;
  logic [DATA_W-1:0] cmp_index_reg;
  logic [ADDR_W-1:0] cmp_addr_reg;
  logic [DATA_W-1:0] cmp_pattern;
  logic              err_reg;
  logic [ADDR_W-1:0] err_addr_reg;

  // Reads run while vindex < N; the vindex == N cycle is the drain cycle in
  // which the last read's data is compared.
  assign verify_rd = (state_reg == S_VERIFY) && (index_reg != len_reg);

  mem_fill_pattern #(.DATA_W(DATA_W)) u_cmp_pattern (
    .mode  (mode_reg),
    .seed  (seed_reg),
    .index (cmp_index_reg),
    .data  (cmp_pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg       <= '0;
      cmp_valid_reg <= 1'b0;
      cmp_index_reg <= '0;
      cmp_addr_reg  <= '0;
      err_reg       <= 1'b0;
      err_addr_reg  <= '0;
    end else begin
      cmp_valid_reg <= verify_rd;
      cmp_index_reg <= index_reg[DATA_W-1:0];
      cmp_addr_reg  <= cur_addr;
      if (start_accept) begin
        len_reg      <= {1'b0, last_addr - first_addr} + (ADDR_W+1)'(1);
        err_reg      <= 1'b0;
        err_addr_reg <= '0;
      end else if (cmp_valid_reg && (ram_rdata != cmp_pattern) && !err_reg) begin
        // Only the first mismatch address is kept.
        err_reg      <= 1'b1;
        err_addr_reg <= cmp_addr_reg;
      end
    end
  end

  assign ram_re   = verify_rd;
  assign err      = err_reg;
  assign err_addr = err_addr_reg;
`else
  logic unused_bits;
  assign unused_bits = ^{ram_rdata, index_reg[ADDR_W]};
  assign ram_re      = 1'b0;
  assign err         = 1'b0;
  assign err_addr    = '0;
`endif

  // State and operation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      index_reg   <= '0;
      aborted_reg <= 1'b0;
      first_reg   <= '0;
      last_reg    <= '0;
      seed_reg    <= '0;
      mode_reg    <= MODE_CONST;
    end else begin
      state_reg   <= state_next;
      index_reg   <= index_next;
      aborted_reg <= aborted_next;
      if (start_accept) begin
        first_reg <= first_addr;
        last_reg  <= last_addr;
        seed_reg  <= fill_data;
        mode_reg  <= mode;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next   = state_reg;
    index_next   = index_reg;
    aborted_next = aborted_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_WRITE;
          index_next   = '0;
          aborted_next = 1'b0;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_next   = S_FIN;
          aborted_next = 1'b1;
        end else if (ram_ready) begin
          index_next = index_reg + (ADDR_W+1)'(1);
          if (cur_addr == last_reg) begin
`ifdef MEM_FILL_VERIFY_EN
            state_next = S_VERIFY;
            index_next = '0;
`else
            state_next = S_FIN;
`endif
          end
        end
      end
`ifdef MEM_FILL_VERIFY_EN
      S_VERIFY: begin
        if (abort) begin
          state_next   = S_FIN;
          aborted_next = 1'b1;
        end else if (index_reg == len_reg) begin
          state_next = S_FIN;
        end else begin
          index_next = index_reg + (ADDR_W+1)'(1);
        end
      end
`endif
      S_FIN: begin
        state_next   = S_IDLE;
        aborted_next = 1'b0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decode from the registered state only.
  always_comb begin
    ram_we   = (state_reg == S_WRITE);
    ram_addr = '0;
    ram_data = '0;
    if (state_reg == S_WRITE) begin
      ram_addr = cur_addr;
      ram_data = wr_pattern;
    end
`ifdef MEM_FILL_VERIFY_EN
    if (verify_rd) begin
      ram_addr = cur_addr;
    end
`endif
  end

  assign done    = (state_reg == S_FIN);
  assign aborted = (state_reg == S_FIN) && aborted_reg;
`ifdef MEM_FILL_VERIFY_EN
  assign busy    = (state_reg == S_WRITE) || (state_reg == S_VERIFY);
`else
  assign busy    = (state_reg == S_WRITE);
`endif

endmodule

// File: tb/tb_mem_fill.sv
// tb_mem_fill: self-checking bench for mem_fill (ADDR_W=6, DATA_W=2).
// Builds with or without MEM_FILL_VERIFY_EN; the expected latency and the
// verify scenario follow the macro.
module tb_mem_fill;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DMOD   = 1 << DATA_W;
`ifdef MEM_FILL_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, abort, ram_ready;
  logic [ADDR_W-1:0] first_addr, last_addr;
  logic [DATA_W-1:0] fill_data, ram_rdata;
  logic [1:0]        mode;
  logic              busy, done, aborted, ram_we, ram_re, err;
  logic [ADDR_W-1:0] ram_addr, err_addr;
  logic [DATA_W-1:0] ram_data;

  mem_fill #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr), .fill_data(fill_data), .mode(mode),
    .busy(busy), .done(done), .aborted(aborted),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_ready(ram_ready),
    .ram_re(ram_re), .ram_rdata(ram_rdata), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_addr[$], exp_data[$];
  int obs_addr[$], obs_data[$];
  int mem_model[DEPTH];
  bit corrupt_en = 1'b0;

  // Reference model: the list of (address, data) writes an operation must make.
  function automatic void build_expected(int f, int l, int m, int fd);
    int n, idx;
    exp_addr.delete();
    exp_data.delete();
    n = ((l - f) % DEPTH + DEPTH) % DEPTH + 1;
    for (int i = 0; i < n; i++) begin
      idx = i % DMOD;
      exp_addr.push_back((f + i) % DEPTH);
      case (m)
        1:       exp_data.push_back((fd + idx) % DMOD);
        2:       exp_data.push_back((idx % 2 == 1) ? (DMOD - 1 - fd) : fd);
        default: exp_data.push_back(fd);
      endcase
    end
  endfunction

  // Expected done cycle with `lows` stalled write cycles and n writes.
  function automatic int exp_done_cycle(int n, int lows);
    return n + lows + 1 + (VERIFY_ON ? n + 1 : 0);
  endfunction

  // Number of positions among the first `limit` expected writes that differ.
  function automatic int seq_mismatches(int limit);
    int mism = 0;
    for (int i = 0; i < limit; i++) begin
      if (i >= obs_addr.size() || i >= exp_addr.size()) mism++;
      else if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) mism++;
    end
    return mism;
  endfunction

  // Drives one operation and records what the DUT does until done (or a
  // cycle budget). Also plays the RAM: ready randomisation, storage and reads.
  task automatic run_op(input int f, input int l, input int m, input int fd,
                        input int ready_pct, input int low_first, input int abort_at,
                        input int ignore_start_at,
                        output int done_cyc, output int lows, output int ab,
                        output int busy_gaps, output int re_out);
    int acc, pend_valid, pend_addr, wr_cycles, val;
    obs_addr.delete();
    obs_data.delete();
    done_cyc = -1; lows = 0; ab = 0; busy_gaps = 0; re_out = 0;
    acc = 0; pend_valid = 0; pend_addr = 0; wr_cycles = 0;
    @(negedge clk);
    start = 1'b1; first_addr = ADDR_W'(f); last_addr = ADDR_W'(l);
    fill_data = DATA_W'(fd); mode = 2'(m); ram_ready = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      ram_rdata = (pend_valid != 0) ? DATA_W'(mem_model[pend_addr]) : '0;
      pend_valid = int'(ram_re);
      pend_addr  = int'(ram_addr);
      if (done) begin
        done_cyc = cyc;
        ab = int'(aborted);
        break;
      end
      if (!busy) busy_gaps++;
      if (ram_re && !VERIFY_ON) re_out++;
      if (cyc == ignore_start_at) begin
        start = 1'b1; first_addr = ADDR_W'(f + 7); last_addr = ADDR_W'(f + 9);
        fill_data = DATA_W'(fd + 1); mode = 2'(m + 1);
      end
      if (ram_we) begin
        wr_cycles++;
        ram_ready = (wr_cycles <= low_first) ? 1'b0 : ($urandom_range(99) < ready_pct);
        if (!ram_ready) lows++;
        else begin
          obs_addr.push_back(int'(ram_addr));
          obs_data.push_back(int'(ram_data));
          val = int'(ram_data);
          if (corrupt_en && ram_addr == 9)  val = 3;
          if (corrupt_en && ram_addr == 12) val = 1;
          mem_model[ram_addr] = val;
          acc++;
          if (acc == abort_at) abort = 1'b1;
        end
      end else begin
        ram_ready = 1'b1;
      end
    end
    $display("op first=%0d last=%0d mode=%0d fill=%0d writes=%0d stalls=%0d done_cycle=%0d aborted=%0d",
             f, l, m, fd, obs_addr.size(), lows, done_cyc, ab);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; ram_ready = 1'b1; ram_rdata = '0;
    first_addr = '0; last_addr = '0; fill_data = '0; mode = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, aborted, ram_we, ram_re, err} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {busy, done, aborted, ram_we, ram_re, err});
    else pass_cnt++;
    total_cnt++;
    if ({ram_addr, ram_data, err_addr} !== '0)
      $display("FAIL reset_buses: got addr=%0d data=%0d err_addr=%0d want 0", ram_addr, ram_data, err_addr);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_full_const();
    int dc, lows, ab, bg, re;
    build_expected(0, 63, 0, 0);
    run_op(0, 63, 0, 0, 100, 0, 0, 0, dc, lows, ab, bg, re);
    total_cnt++;
    if (obs_addr.size() !== 64) $display("FAIL full_count: got %0d want 64", obs_addr.size());
    else pass_cnt++;
    total_cnt++;
    if (seq_mismatches(64) !== 0) $display("FAIL full_seq: got %0d bad writes want 0", seq_mismatches(64));
    else pass_cnt++;
    total_cnt++;
    if (dc !== exp_done_cycle(64, 0)) $display("FAIL full_done_cycle: got %0d want %0d", dc, exp_done_cycle(64, 0));
    else pass_cnt++;
    total_cnt++;
    if ({ab, bg, re} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL full_status: got aborted=%0d busy_gaps=%0d ram_re=%0d want 0", ab, bg, re);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL full_busy_at_done: got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_wrap_inc();
    int dc, lows, ab, bg, re;
    build_expected(60, 3, 1, 1);
    run_op(60, 3, 1, 1, 100, 0, 0, 0, dc, lows, ab, bg, re);
    total_cnt++;
    if (obs_addr.size() !== 8 || seq_mismatches(8) !== 0)
      $display("FAIL wrap_seq: got %0d writes %0d bad want 8 writes 0 bad", obs_addr.size(), seq_mismatches(8));
    else pass_cnt++;
    total_cnt++;
    if (dc !== exp_done_cycle(8, 0)) $display("FAIL wrap_done_cycle: got %0d want %0d", dc, exp_done_cycle(8, 0));
    else pass_cnt++;
  endtask

  task automatic test_single_backpressure();
    int dc, lows, ab, bg, re, extra;
    build_expected(17, 17, 2, 2);
    run_op(17, 17, 2, 2, 100, 3, 0, 0, dc, lows, ab, bg, re);
    total_cnt++;
    if (obs_addr.size() !== 1 || seq_mismatches(1) !== 0)
      $display("FAIL single_seq: got %0d writes addr=%0d want 1 write of 2 to 17", obs_addr.size(),
               (obs_addr.size() > 0) ? obs_addr[0] : -1);
    else pass_cnt++;
    total_cnt++;
    if (lows !== 3 || dc !== exp_done_cycle(1, 3))
      $display("FAIL single_timing: got stalls=%0d done=%0d want 3 and %0d", lows, dc, exp_done_cycle(1, 3));
    else pass_cnt++;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL single_done_once: got %0d extra done pulses want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int dc, lows, ab, bg, re;
    build_expected(0, 63, 0, 3);
    run_op(0, 63, 0, 3, 100, 0, 5, 2, dc, lows, ab, bg, re);
    total_cnt++;
    if (obs_addr.size() !== 5 || seq_mismatches(5) !== 0)
      $display("FAIL abort_writes: got %0d writes %0d bad want 5 writes 0 bad", obs_addr.size(), seq_mismatches(5));
    else pass_cnt++;
    total_cnt++;
    if (ab !== 1 || dc !== 6) $display("FAIL abort_done: got aborted=%0d done=%0d want 1 and 6", ab, dc);
    else pass_cnt++;
    total_cnt++;
    if (ram_we !== 1'b0) $display("FAIL abort_we_drop: got %b want 0", ram_we);
    else pass_cnt++;
    // Start in the cycle right after done must be accepted.
    build_expected(10, 12, 1, 0);
    run_op(10, 12, 1, 0, 100, 0, 0, 0, dc, lows, ab, bg, re);
    total_cnt++;
    if (obs_addr.size() !== 3 || seq_mismatches(3) !== 0 || dc !== exp_done_cycle(3, 0) || ab !== 0)
      $display("FAIL after_abort_op: got %0d writes done=%0d aborted=%0d want 3, %0d, 0",
               obs_addr.size(), dc, ab, exp_done_cycle(3, 0));
    else pass_cnt++;
  endtask

  task automatic test_random();
    int dc, lows, ab, bg, re, f, l, m, fd, n;
    for (int k = 0; k < 8; k++) begin
      f  = int'($urandom_range(DEPTH - 1));
      l  = (k == 0) ? (f + DEPTH - 1) % DEPTH : int'($urandom_range(DEPTH - 1));
      m  = int'($urandom_range(3));
      fd = int'($urandom_range(DMOD - 1));
      build_expected(f, l, m, fd);
      n = exp_addr.size();
      run_op(f, l, m, fd, 60, 0, 0, 0, dc, lows, ab, bg, re);
      total_cnt++;
      if (obs_addr.size() !== n || seq_mismatches(n) !== 0)
        $display("FAIL rand_seq[%0d]: got %0d writes %0d bad want %0d writes 0 bad", k, obs_addr.size(),
                 seq_mismatches(n), n);
      else pass_cnt++;
      total_cnt++;
      if (dc !== exp_done_cycle(n, lows) || ab !== 0 || bg !== 0 || re !== 0 || err !== 1'b0)
        $display("FAIL rand_status[%0d]: got done=%0d aborted=%0d gaps=%0d re=%0d err=%b want %0d,0,0,0,0",
                 k, dc, ab, bg, re, err, exp_done_cycle(n, lows));
      else pass_cnt++;
    end
  endtask

  task automatic test_rst_mid();
    int dc, lows, ab, bg, re;
    @(negedge clk);
    start = 1'b1; first_addr = '0; last_addr = 6'd63; fill_data = 2'd1; mode = 2'd0; ram_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({busy, done, aborted, ram_we, ram_re, err} !== 6'b0 || ram_addr !== '0 || ram_data !== '0)
      $display("FAIL rst_mid_outputs: got flags=%b addr=%0d data=%0d want all 0",
               {busy, done, aborted, ram_we, ram_re, err}, ram_addr, ram_data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL rst_mid_no_done: got done=%b busy=%b want 0 0", done, busy);
    else pass_cnt++;
    build_expected(5, 9, 2, 1);
    run_op(5, 9, 2, 1, 100, 0, 0, 0, dc, lows, ab, bg, re);
    total_cnt++;
    if (obs_addr.size() !== 5 || seq_mismatches(5) !== 0 || dc !== exp_done_cycle(5, 0))
      $display("FAIL rst_mid_fresh_op: got %0d writes done=%0d want 5, %0d", obs_addr.size(), dc,
               exp_done_cycle(5, 0));
    else pass_cnt++;
  endtask

`ifdef MEM_FILL_VERIFY_EN
  task automatic test_verify();
    int dc, lows, ab, bg, re;
    corrupt_en = 1'b1;
    build_expected(0, 15, 0, 0);
    run_op(0, 15, 0, 0, 100, 0, 0, 0, dc, lows, ab, bg, re);
    corrupt_en = 1'b0;
    total_cnt++;
    if (err !== 1'b1 || err_addr !== 6'd9)
      $display("FAIL verify_err: got err=%b err_addr=%0d want 1 and 9", err, err_addr);
    else pass_cnt++;
    total_cnt++;
    if (dc !== 34) $display("FAIL verify_done_cycle: got %0d want 34", dc);
    else pass_cnt++;
    build_expected(0, 3, 0, 1);
    run_op(0, 3, 0, 1, 100, 0, 0, 0, dc, lows, ab, bg, re);
    total_cnt++;
    if (err !== 1'b0 || err_addr !== '0)
      $display("FAIL verify_err_clear: got err=%b err_addr=%0d want 0 and 0", err, err_addr);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_const();
    test_wrap_inc();
    test_single_backpressure();
    test_abort();
    test_random();
    test_rst_mid();
`ifdef MEM_FILL_VERIFY_EN
    test_verify();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_fill.md
Name: mem_fill

Overview:
- Parametrised successor to the board-memory clear engine.
- Writes a programmable pattern over an inclusive address range of a single-port RAM, one write per accepted cycle.
- Adds start/done handshake, RAM-side backpressure, selectable fill pattern, abort and an optional read-back verify pass.
- Sits between the game controller (board reset, region clear, test patterns) and the board-RAM arbiter.

Parameters:
- ADDR_W, 6, RAM address width; address space is 2^ADDR_W entries.
- DATA_W, 2, RAM data width, one board point per entry.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  stop the current operation; wins over everything except rst.
- first_addr  in  ADDR_W  first address written; sampled with start.
- last_addr  in  ADDR_W  last address written, inclusive; sampled with start.
- fill_data  in  DATA_W  pattern seed; sampled with start.
- mode  in  2  0 constant, 1 increment, 2 alternate, 3 reserved (treated as constant); sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the operation ends.
- aborted  out  1  valid with done; 1 if the operation ended via abort.
- ram_we  out  1  write request.
- ram_addr  out  ADDR_W  write/read address.
- ram_data  out  DATA_W  write data.
- ram_ready  in  1  write accepted when ram_we && ram_ready.
- ram_re  out  1  read strobe; verify only.
- ram_rdata  in  DATA_W  read data, valid one cycle after ram_re.
- err  out  1  verify mismatch seen; sticky until next accepted start.
- err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset: state IDLE; busy, done, aborted, ram_we, ram_re, err = 0; ram_addr, ram_data, err_addr = 0. rst mid-operation abandons the operation immediately, with no done pulse.
- States: IDLE, WRITE, VERIFY (only with the macro), FIN.
- IDLE -> WRITE: when start=1. The cycle start is sampled, the block latches first_addr, last_addr, fill_data and mode, clears index and err, and sets busy next cycle. start outside IDLE is ignored.
- WRITE:
  - ram_we=1, ram_addr = first_addr + index (mod 2^ADDR_W), ram_data = pattern(index).
  - index increments only on an accepted write. Outputs hold while ram_ready=0.
  - On acceptance at ram_addr == last_addr: go to VERIFY if enabled, else FIN.
- Range length N = ((last_addr - first_addr) mod 2^ADDR_W) + 1.
  - first_addr > last_addr wraps through the top address.
  - first_addr == last_addr writes exactly one entry.
  - Full range is first = last + 1 mod 2^ADDR_W, i.e. N = 2^ADDR_W.
- Index counter is ADDR_W+1 bits wide so a full range does not alias.
- Pattern, with index taken as the write count modulo 2^DATA_W:
  - constant: fill_data.
  - increment: fill_data + index, truncated to DATA_W.
  - alternate: fill_data on even index, ~fill_data on odd index.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. A new start is accepted in the cycle after FIN.
- Latency with ram_ready held high:
  - start at cycle 0, writes in cycles 1..N, done in cycle N+1.
  - Each low cycle of ram_ready adds one cycle.
- Abort:
  - If abort=1 in WRITE or VERIFY: ram_we and ram_re drop the next cycle, the block goes to FIN, and done is asserted with aborted=1.
  - A write accepted in the same cycle as abort counts as performed.
  - aborted is cleared in any cycle without done.
- ram_re is always 0 outside VERIFY.

Optional Feature:
- Macro: MEM_FILL_VERIFY_EN.
- With the macro, VERIFY pass:
  - ram_re=1 for N consecutive cycles, no backpressure, ram_addr = first_addr + vindex.
  - Each ram_rdata is compared one cycle later against pattern(vindex).
  - The first mismatch sets err=1 and latches err_addr. Later mismatches do not overwrite err_addr.
  - The pass always runs to the end unless aborted.
  - done arrives 2 cycles after the last ram_re, so full-range latency is 2N+2.
- Without the macro: no VERIFY state; ram_re, err and err_addr are tied 0; ram_rdata is ignored.

Decomposition:
- Package mem_fill_pkg: mode constants MODE_CONST, MODE_INC, MODE_ALT; state encodings.
- Sub-module mem_fill_pattern: combinational, (mode, seed, index) -> data. One instance serves the write path; with the macro, a second instance serves the compare path.

Test Plan:
- ADDR_W=6, first=0, last=63, mode=0, fill=2'b00, ready=1: 64 writes in cycles 1..64 with addr 0..63 and data 0; done in cycle 65; aborted=0.
- first=60, last=3, mode=1, fill=2'b01: addresses 60,61,62,63,0,1,2,3 with data 1,2,3,0,1,2,3,0; done after 8 writes.
- first=last=17, mode=2, fill=2'b10, ram_ready low for 3 cycles: a single write of 2 to address 17, held for 3 cycles then accepted; done exactly once.
- Abort asserted on the 5th accepted write of a 0..63 fill: ram_we=0 the next cycle; done=1 with aborted=1; start in the cycle after done is accepted; start pulsed while busy is ignored.
- With MEM_FILL_VERIFY_EN, RAM model corrupts address 9 to 3 and address 12 to 1 during a constant-0 fill of 0..15: err=1, err_addr=9, done at cycle 34; err is cleared by the next start.
- rst asserted in the middle of WRITE: the next cycle shows IDLE with all outputs 0 and no done pulse; a fresh start then behaves normally.
